// File: rtl/bus_pkg.sv
// Shared types and helpers for the core data bus: master ids, request bundle
// and the round-robin pick used by the arbiter.
package bus_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int BUS_AW      = 32;
    localparam int BUS_DW      = 32;

    typedef logic mid_t;

    typedef struct packed {
        logic                  we;
        logic [BUS_DW/8-1:0]   be;
        logic [BUS_AW-1:0]     addr;
        logic [BUS_DW-1:0]     wdata;
    } bus_req_t;

    // On a tie the master that did not win last time goes first.
    function automatic mid_t rr_pick(input logic req0, input logic req1, input mid_t last);
        if (req0 && req1) begin
            return ~last;
        end
        return mid_t'(req1);
    endfunction

endpackage

// File: rtl/id_fifo.sv
// Small FIFO of master ids for granted transactions still waiting on rvalid.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module id_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == CW'(DEPTH));
    assign count_o = r_count;
    assign rdata_o = r_mem[r_rptr];

    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter in front of the data RAM, with request locking
// while waiting for grant and in-order routing of responses back to their issuer.
module data_bus_arbiter
    import bus_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             m0_req_i,
    output logic             m0_gnt_o,
    input  logic             m0_we_i,
    input  logic [DW/8-1:0]  m0_be_i,
    input  logic [AW-1:0]    m0_addr_i,
    input  logic [DW-1:0]    m0_wdata_i,
    output logic             m0_rvalid_o,
    output logic [DW-1:0]    m0_rdata_o,

    input  logic             m1_req_i,
    output logic             m1_gnt_o,
    input  logic             m1_we_i,
    input  logic [DW/8-1:0]  m1_be_i,
    input  logic [AW-1:0]    m1_addr_i,
    input  logic [DW-1:0]    m1_wdata_i,
    output logic             m1_rvalid_o,
    output logic [DW-1:0]    m1_rdata_o,

    output logic             s_req_o,
    output logic             s_we_o,
    output logic [DW/8-1:0]  s_be_o,
    output logic [AW-1:0]    s_addr_o,
    output logic [DW-1:0]    s_wdata_o,
    input  logic             s_gnt_i,
    input  logic             s_rvalid_i,
    input  logic [DW-1:0]    s_rdata_i,

    output logic             err_o
);

    localparam int CW = $clog2(OUTSTANDING) + 1;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t r_state;
    mid_t   r_last;
    mid_t   r_sel;
    logic   r_err;

    mid_t          w_sel;
    logic          w_winner_valid;
    logic          w_full;
    logic          w_empty;
    mid_t          w_head;
    logic          w_pop;
    logic          w_hs;
    logic [CW-1:0] w_unused_count;

    always_comb begin
        w_sel          = 1'b0;
        w_winner_valid = 1'b0;
        if (r_state == ST_HOLD) begin
            w_sel          = r_sel;
            w_winner_valid = r_sel ? m1_req_i : m0_req_i;
        end else begin
            w_sel          = rr_pick(m0_req_i, m1_req_i, r_last);
            w_winner_valid = m0_req_i | m1_req_i;
        end
    end

    // A full FIFO may still accept a request when a response frees a slot this cycle.
    assign s_req_o  = ~rst_i & w_winner_valid & (~w_full | s_rvalid_i);
    assign w_hs     = s_req_o & s_gnt_i;
    assign m0_gnt_o = w_hs & (w_sel == 1'b0);
    assign m1_gnt_o = w_hs & (w_sel == 1'b1);

    assign s_we_o    = w_sel ? m1_we_i    : m0_we_i;
    assign s_be_o    = w_sel ? m1_be_i    : m0_be_i;
    assign s_addr_o  = w_sel ? m1_addr_i  : m0_addr_i;
    assign s_wdata_o = w_sel ? m1_wdata_i : m0_wdata_i;

    assign w_pop       = s_rvalid_i & ~w_empty;
    assign m0_rvalid_o = ~rst_i & w_pop & (w_head == 1'b0);
    assign m1_rvalid_o = ~rst_i & w_pop & (w_head == 1'b1);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign err_o       = r_err;

    id_fifo #(
        .DEPTH (OUTSTANDING),
        .W     (1)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_hs),
        .pop_i   (w_pop),
        .wdata_i (w_sel),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_unused_count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_ARB;
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (s_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_ARB: begin
                    if (w_hs) begin
                        r_last <= w_sel;
                    end else if (w_winner_valid) begin
                        r_sel   <= w_sel;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Dropping req before grant is a master protocol violation.
                    if (w_hs) begin
                        r_last  <= r_sel;
                        r_state <= ST_ARB;
                    end else if (!w_winner_valid) begin
                        r_err   <= 1'b1;
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: directed scenarios followed by random traffic.
module tb_data_bus_arbiter;

    localparam int OUTSTANDING = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m_req   [2];
    logic        m_we    [2];
    logic [3:0]  m_be    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        s_gnt_i, s_rvalid_i;
    logic [31:0] s_rdata_i;

    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic        err_o;

    always #5 clk = ~clk;

    data_bus_arbiter #(.AW(32), .DW(32), .OUTSTANDING(OUTSTANDING)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m_req[0]), .m0_gnt_o(m0_gnt_o), .m0_we_i(m_we[0]), .m0_be_i(m_be[0]),
        .m0_addr_i(m_addr[0]), .m0_wdata_i(m_wdata[0]), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m_req[1]), .m1_gnt_o(m1_gnt_o), .m1_we_i(m_we[1]), .m1_be_i(m_be[1]),
        .m1_addr_i(m_addr[1]), .m1_wdata_i(m_wdata[1]), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .err_o(err_o)
    );

    typedef struct { int id; logic [31:0] data; } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          mlast, mlock;
    bit          merr;
    int          mq[$];
    exp_t        sb[$];
    logic [31:0] slave_q[$];
    bit          g0, g1;
    bit          busy [2];

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a ^ 32'hDEADBEFF;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mlast = 1; mlock = -1; merr = 1'b0;
        mq.delete(); sb.delete(); slave_q.delete();
        busy[0] = 1'b0; busy[1] = 1'b0;
    endtask

    // Reference: decide this cycle's winner from the arbitration rules, compare, advance.
    task automatic model_step();
        int w;
        bit wv, full, pop, esreq, hs;
        if (mlock >= 0) begin
            w  = mlock;
            wv = m_req[mlock];
        end else begin
            wv = m_req[0] | m_req[1];
            w  = (m_req[0] && m_req[1]) ? 1 - mlast : (m_req[1] ? 1 : 0);
        end
        full  = (mq.size() >= OUTSTANDING);
        pop   = s_rvalid_i && (mq.size() > 0);
        esreq = wv && (!full || s_rvalid_i);
        hs    = esreq && s_gnt_i;
        chk1("s_req", s_req_o, esreq);
        chk1("m0_gnt", m0_gnt_o, hs && (w == 0));
        chk1("m1_gnt", m1_gnt_o, hs && (w == 1));
        chk1("rvalid_any", m0_rvalid_o | m1_rvalid_o, pop);
        chk1("err", err_o, merr);
        if (esreq) begin
            chk32("s_addr", s_addr_o, m_addr[w]);
            chk32("s_wdata", s_wdata_o, m_wdata[w]);
            chk1("s_we", s_we_o, m_we[w]);
            chk32("s_be", {28'd0, s_be_o}, {28'd0, m_be[w]});
        end
        if (s_rvalid_i && mq.size() == 0) merr = 1'b1;
        if (pop) void'(mq.pop_front());
        if (hs) begin
            mq.push_back(w);
            sb.push_back('{w, rd_of(m_addr[w])});
            mlast = w;
            mlock = -1;
        end else if (mlock >= 0 && !wv) begin
            merr  = 1'b1;
            mlock = -1;
        end else if (wv) begin
            mlock = w;
        end
    endtask

    // rv_mode: 0 = slave silent, 1 = answer oldest accepted request if any, 2 = spurious rvalid
    task automatic tick(input int rv_mode);
        s_rvalid_i = 1'b0;
        s_rdata_i  = $urandom;
        if (rv_mode == 2) begin
            s_rvalid_i = 1'b1;
        end else if (rv_mode == 1 && slave_q.size() > 0) begin
            s_rvalid_i = 1'b1;
            s_rdata_i  = slave_q.pop_front();
        end
        @(negedge clk);
        model_step();
        g0 = m0_gnt_o;
        g1 = m1_gnt_o;
        if (s_req_o && s_gnt_i) slave_q.push_back(rd_of(s_addr_o));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk1("rst_s_req", s_req_o, 1'b0);
        chk1("rst_m0_gnt", m0_gnt_o, 1'b0);
        chk1("rst_m1_gnt", m1_gnt_o, 1'b0);
        chk1("rst_m0_rvalid", m0_rvalid_o, 1'b0);
        chk1("rst_m1_rvalid", m1_rvalid_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
    endtask

    task automatic do_reset();
        #2 rst_i = 1'b1;
        #1 chk_reset_outputs();
        model_reset();
        m_req[0] = 1'b0; m_req[1] = 1'b0;
        s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        m_req[0] = 1'b0; m_req[1] = 1'b0;
        for (int i = 0; i < 6; i++) tick(1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_i && (m0_rvalid_o || m1_rvalid_o)) begin
            chk1("rv_onehot", m0_rvalid_o & m1_rvalid_o, 1'b0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rv_unexpected: rvalid m0=%0b m1=%0b with no outstanding request", m0_rvalid_o, m1_rvalid_o);
            end else begin
                e = sb.pop_front();
                chk1("rv_route", m1_rvalid_o, e.id == 1);
                chk32("rv_data", m1_rvalid_o ? m1_rdata_o : m0_rdata_o, e.data);
            end
        end
    end

    initial begin
        bit prev_g0;
        int n_g0;
        rst_i = 1'b1;
        for (int x = 0; x < 2; x++) begin
            m_req[x] = 1'b0; m_we[x] = 1'b0; m_be[x] = 4'hF; m_addr[x] = '0; m_wdata[x] = '0;
        end
        s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
        model_reset();
        #1 chk_reset_outputs();
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Single master read
        m_req[0] = 1'b1; m_addr[0] = 32'h10; s_gnt_i = 1'b1;
        tick(0);
        chk1("t1_gnt_pulse", g0, 1'b1);
        m_req[0] = 1'b0;
        tick(1);
        chk1("t1_gnt_once", g0, 1'b0);
        drain();

        // Contention with slave always granting and answering next cycle
        m_req[0] = 1'b1; m_req[1] = 1'b1; m_addr[0] = 32'h100; m_addr[1] = 32'h200;
        s_gnt_i = 1'b1;
        n_g0 = 0;
        prev_g0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk1("t2_alternate", g0, ~prev_g0);
            prev_g0 = g0;
            if (g0) begin n_g0++; m_addr[0] += 4; end
            if (g1) m_addr[1] += 4;
        end
        chk32("t2_m0_share", n_g0, 4);
        drain();

        // Hold lock: m0 waits for grant while m1 joins
        m_req[0] = 1'b1; m_addr[0] = 32'h300; s_gnt_i = 1'b0;
        tick(0);
        m_req[1] = 1'b1; m_addr[1] = 32'h400;
        tick(0);
        tick(0);
        s_gnt_i = 1'b1;
        tick(0);
        chk1("t3_m0_first", g0, 1'b1);
        m_req[0] = 1'b0;
        tick(0);
        chk1("t3_m1_second", g1, 1'b1);
        drain();

        // FIFO full, then a request accepted alongside a response
        m_req[0] = 1'b1; m_addr[0] = 32'h500; s_gnt_i = 1'b1;
        tick(0);
        m_req[0] = 1'b0; m_req[1] = 1'b1; m_addr[1] = 32'h600;
        tick(0);
        m_req[1] = 1'b0; m_req[0] = 1'b1; m_addr[0] = 32'h504;
        tick(0);
        chk1("t4_full_blocks", g0, 1'b0);
        tick(1);
        chk1("t4_pop_push", g0, 1'b1);
        drain();

        // Spurious response sets a sticky error
        tick(2);
        tick(0);
        tick(0);
        chk1("t5_err_sticky", err_o, 1'b1);
        do_reset();

        // Request dropped while locked
        m_req[1] = 1'b1; m_addr[1] = 32'h700; s_gnt_i = 1'b0;
        tick(0);
        m_req[1] = 1'b0;
        tick(0);
        tick(0);
        chk1("t6_drop_err", err_o, 1'b1);

        // Asynchronous reset mid-transaction, then a stale response
        m_req[0] = 1'b1; m_addr[0] = 32'h800; s_gnt_i = 1'b1;
        tick(0);
        m_req[1] = 1'b1; s_rvalid_i = 1'b1;
        do_reset();
        tick(2);
        tick(0);
        chk1("t7_stale_rvalid_err", err_o, 1'b1);
        do_reset();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int x = 0; x < 2; x++) begin
                if (!busy[x] && $urandom_range(0, 9) < 6) begin
                    busy[x]    = 1'b1;
                    m_addr[x]  = $urandom & 32'hFFFF_FFFC;
                    m_we[x]    = 1'($urandom_range(0, 1));
                    m_be[x]    = 4'($urandom);
                    m_wdata[x] = $urandom;
                end
            end
            m_req[0] = busy[0]; m_req[1] = busy[1];
            s_gnt_i  = ($urandom_range(0, 3) != 0);
            tick(($urandom_range(0, 2) != 0) ? 1 : 0);
            if (g0) busy[0] = 1'b0;
            if (g1) busy[1] = 1'b0;
        end
        s_gnt_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            m_req[0] = busy[0]; m_req[1] = busy[1];
            tick(1);
            if (g0) busy[0] = 1'b0;
            if (g1) busy[1] = 1'b0;
        end
        chk32("end_sb_empty", sb.size(), 0);
        chk1("end_no_err", err_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master, one-slave arbiter for the core data bus: shares the single data RAM between the milano load/store port (master 0) and a second requester (master 1, loader/DMA) using the same req/gnt/rvalid protocol the core already speaks. Sits between the core data interface and `data_ram`. It provides:

- round-robin arbitration;
- locking of the selected master while a request waits for grant;
- tracking of up to `OUTSTANDING` granted-but-unanswered transactions, so each `rvalid` and its `rdata` are routed back to the master that issued the request.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (byte enables are `DW/8`)
- `OUTSTANDING`, 2, max accepted transactions awaiting `rvalid`; power of two, at least 1

Ports (x = 0, 1):
- `clk_i`  in  1  single clock, all logic on rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `mx_req_i`  in  1  master x request
- `mx_gnt_o`  out  1  master x grant
- `mx_we_i`  in  1  write enable
- `mx_be_i`  in  DW/8  byte enables
- `mx_addr_i`  in  AW  address
- `mx_wdata_i`  in  DW  write data
- `mx_rvalid_o`  out  1  response valid, routed to the master that owns the response
- `mx_rdata_o`  out  DW  read data, broadcast to both masters and valid only when that master's `rvalid` is high
- `s_req_o`, `s_we_o`, `s_be_o`, `s_addr_o`, `s_wdata_o`  out  slave request channel
- `s_gnt_i`  in  1  slave grant
- `s_rvalid_i`  in  1  slave response valid
- `s_rdata_i`  in  DW  slave read data
- `err_o`  out  1  sticky protocol error; cleared only by reset

## Operation
State machine, two states:
- **ARB** (reset state):
  - Winner selection:
    - If only one master requests, that master wins.
    - If both request, the master other than `last_q` wins.
    - `last_q` resets to 1, so master 0 wins the first tie.
  - `s_req_o = winner_valid & ~fifo_full`.
  - Handshake (`s_req_o & s_gnt_i`): push the winner's id into the id FIFO, set `last_q` = winner, stay in ARB.
  - Request without grant: latch the winner into `sel_q`, go to HOLD.
- **HOLD**:
  - Selection is forced to `sel_q`; the other master is ignored.
  - Handshake: push `sel_q`, set `last_q` = `sel_q`, return to ARB.
  - If `mx_req_i` of `sel_q` drops (master protocol violation): set `err_o`, return to ARB, push nothing.
- Request channel:
  - `s_we/be/addr/wdata` are muxed from the selected master.
  - `mx_gnt_o = s_gnt_i & s_req_o & (sel == x)`.
- Response routing:
  - `s_rvalid_i` pops the FIFO head id; `m<head>_rvalid_o = s_rvalid_i`.
  - `s_rvalid_i` with the FIFO empty: no `rvalid` out, set `err_o`.
- Full FIFO:
  - `s_req_o` is held low; no grant is passed through.
  - Exception: if `s_rvalid_i` is high in the same cycle, request and push are allowed (simultaneous pop+push, count unchanged).
- Count arithmetic: width `$clog2(OUTSTANDING)+1`; it never exceeds `OUTSTANDING` and never underflows.

## Timing
- Zero added latency:
  - `mx_req_i` to `s_req_o` is combinational.
  - `s_gnt_i` to `mx_gnt_o` is combinational.
  - `s_rvalid_i`/`s_rdata_i` to `mx_rvalid_o`/`mx_rdata_o` is combinational, using the registered FIFO head.
- Reset values: `s_req_o`=0, all `gnt`=0, all `rvalid`=0, `err_o`=0, FIFO empty, state ARB, `last_q`=1. Data outputs are don't-care but driven from master 0 muxing.
- Reset mid-transaction discards all outstanding ids; responses arriving after reset release set `err_o`.
- Back-to-back: with `s_gnt_i` tied high and both masters requesting every cycle, grants alternate 0,1,0,1 and each master gets one grant every 2 cycles.
- Simultaneous events:
  - Same-cycle push (grant) and pop (`rvalid`) update the FIFO correctly for any count.
  - The popped entry is the oldest; responses are strictly in order.

## Structure
- Shared package `bus_pkg`: `mid_t` (1-bit master id), `NUM_MASTERS = 2`, request struct `bus_req_t {we, be, addr, wdata}` parameterised by the AW/DW defaults.
- Sub-module `id_fifo`:
  - Parameters: DEPTH, type/width.
  - Ports: push, pop, wdata, rdata (head), full, empty, count.
  - Async active-high reset.
- Top holds the FSM, round-robin pointer, request mux and response demux.

## Test plan
- **Single master read:** m0 reads addr 0x10, slave `gnt` on first cycle, `rvalid` 1 cycle later with 0xDEADBEEF → `m0_gnt` pulses once, `m0_rvalid` with 0xDEADBEEF, `m1_rvalid` stays 0.
- **Contention:** both masters request continuously, `s_gnt_i`=1, slave answers next cycle → grants 0,1,0,1; `rvalid` routed in the same order; `count` ≤ 2.
- **Hold lock:** m0 requests, `s_gnt_i` low for 3 cycles while m1 also requests → `s_addr_o` stays at m0's address for all 3 cycles; m0 is granted first, then m1.
- **FIFO full:** `OUTSTANDING`=2, two grants with no `rvalid` → `s_req_o` drops. A third request coinciding with `s_rvalid_i` → accepted same cycle; the first response goes to the first granted master.
- **Error cases:** `s_rvalid_i` with the FIFO empty → `err_o`=1 and stays 1. Separately, m1 drops `req` in HOLD → `err_o`=1. Assert `rst_i` asynchronously mid-transaction → all outputs return to reset values immediately.
